// File: rtl/beep_tone_player.sv
// Debounced 4-key note decoder driving a PWM passive buzzer with run-time volume and octave.
// Define AUTO_PLAY_EN to add the play_start input and the built-in 8-note scale sequencer.
module beep_tone_player #(
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter int unsigned CNT_W        = 18,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned GAP_CYC      = 500_000
`ifdef AUTO_PLAY_EN
  , parameter int unsigned NOTE_LEN_CYC = 12_500_000
`endif
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  input  logic [3:0] volume,
  input  logic [1:0] octave,
`ifdef AUTO_PLAY_EN
  input  logic       play_start,
`endif
  output logic       beep,
  output logic [3:0] led,
  output logic [2:0] note_idx,
  output logic       busy
);

  localparam int unsigned DB_W     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam int unsigned PRD_W    = CNT_W + 4;

  localparam logic [CNT_W-1:0] DIV_DO = CNT_W'(CLK_FREQ_HZ / 262);
  localparam logic [CNT_W-1:0] DIV_RE = CNT_W'(CLK_FREQ_HZ / 294);
  localparam logic [CNT_W-1:0] DIV_MI = CNT_W'(CLK_FREQ_HZ / 330);
  localparam logic [CNT_W-1:0] DIV_FA = CNT_W'(CLK_FREQ_HZ / 349);
  localparam logic [CNT_W-1:0] DIV_SO = CNT_W'(CLK_FREQ_HZ / 392);
  localparam logic [CNT_W-1:0] DIV_LA = CNT_W'(CLK_FREQ_HZ / 440);
  localparam logic [CNT_W-1:0] DIV_XI = CNT_W'(CLK_FREQ_HZ / 494);

  typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP} state_e;

  logic [3:0]        sync_q1, sync_q2;
  logic [DB_W-1:0]   db_cnt [4];
  logic [2:0]        key_note, note_req;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, per_q, per_d, thr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [2:0]        note_q, note_d;
  logic              per_end;

  // Period for a note/octave pair, clamped so the PWM counter always has two phases.
  function automatic logic [CNT_W-1:0] calc_per(input logic [2:0] n, input logic [1:0] o);
    logic [CNT_W-1:0] d, p;
    case (n)
      3'd2:    d = DIV_RE;
      3'd3:    d = DIV_MI;
      3'd4:    d = DIV_FA;
      3'd5:    d = DIV_SO;
      3'd6:    d = DIV_LA;
      3'd7:    d = DIV_XI;
      default: d = DIV_DO;
    endcase
    p = d >> o;
    return (p < CNT_W'(2)) ? CNT_W'(2) : p;
  endfunction

  // Key synchroniser and per-key stability counters; led holds the inverted debounced keys.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 4'hF;
      sync_q2 <= 4'hF;
      led     <= 4'h0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync_q1 <= key;
      sync_q2 <= sync_q1;
      for (int i = 0; i < 4; i++) begin
        if (sync_q2[i] == ~led[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          db_cnt[i] <= '0;
          led[i]    <= ~sync_q2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    key_note = 3'd0;
    case (~led)
      4'b0111: key_note = 3'd1;
      4'b1011: key_note = 3'd2;
      4'b1101: key_note = 3'd3;
      4'b1110: key_note = 3'd4;
      4'b0011: key_note = 3'd5;
      4'b0101: key_note = 3'd6;
      4'b0110: key_note = 3'd7;
      default: key_note = 3'd0;
    endcase
  end

`ifdef AUTO_PLAY_EN
  localparam int unsigned LEN_W = (NOTE_LEN_CYC > 1) ? $clog2(NOTE_LEN_CYC) : 1;

  logic             play_q, seq_on;
  logic [2:0]       seq_step;
  logic [LEN_W-1:0] seq_len;

  // Scale sequencer: 1..7 then 1 again; any debounced key press hands control back to the keys.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      play_q   <= 1'b0;
      seq_on   <= 1'b0;
      seq_step <= 3'd0;
      seq_len  <= '0;
    end else begin
      play_q <= play_start;
      if (led != 4'h0) begin
        seq_on <= 1'b0;
      end else if (!seq_on && play_start && !play_q && state_q == S_IDLE) begin
        seq_on   <= 1'b1;
        seq_step <= 3'd0;
        seq_len  <= '0;
      end else if (seq_on) begin
        if (seq_len == LEN_W'(NOTE_LEN_CYC - 1)) begin
          seq_len <= '0;
          if (seq_step == 3'd7) seq_on <= 1'b0;
          else                  seq_step <= seq_step + 3'd1;
        end else begin
          seq_len <= seq_len + LEN_W'(1);
        end
      end
    end
  end

  assign note_req = !seq_on ? key_note : (seq_step == 3'd7) ? 3'd1 : seq_step + 3'd1;
`else
  assign note_req = key_note;
`endif

  assign per_end = (cnt_q == per_q - CNT_W'(1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      per_q    <= '0;
      gap_q    <= '0;
      note_q   <= 3'd0;
      beep     <= 1'b0;
      note_idx <= 3'd0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      gap_q    <= gap_d;
      note_q   <= note_d;
      beep     <= (state_d == S_TONE) && (cnt_d < thr_d);
      note_idx <= (state_d == S_TONE) ? note_d : 3'd0;
      busy     <= (state_d != S_IDLE);
    end
  end

  // Note/octave change only at a period boundary, so every started period runs to completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    gap_d   = gap_q;
    note_d  = note_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (note_req != 3'd0) begin
          note_d  = note_req;
          per_d   = calc_per(note_req, octave);
          state_d = S_TONE;
        end
      end
      S_TONE: begin
        if (!per_end) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (note_req == note_q) begin
            per_d = calc_per(note_q, octave);
          end else if (note_req == 3'd0) begin
            state_d = S_IDLE;
          end else if (GAP_CYC > 0) begin
            state_d = S_GAP;
            gap_d   = '0;
          end else begin
            note_d = note_req;
            per_d  = calc_per(note_req, octave);
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) begin
          if (note_req != 3'd0) begin
            note_d  = note_req;
            per_d   = calc_per(note_req, octave);
            state_d = S_TONE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // High time follows the live volume; the product keeps 4 guard bits before the >>5.
  assign thr_d = CNT_W'((PRD_W'(per_d) * PRD_W'(volume)) >> 5);

endmodule
